// File: rtl/encode_upperimm_seq.sv
// encode_upperimm_seq
//    Turns a 32-bit constant (mode 0) or PC offset (mode 1) into an RV32I
//    LUI/AUIPC + ADDI pair, streamed one word per out_valid/out_ready beat.
//
//    Handshake: a transfer happens on a rising edge where valid and ready
//    are both high. out_instr/out_last hold steady while out_valid is high
//    and out_ready is low. in_* is ignored unless in_ready is high.
//
//    Optional macro UPPERIMM_SKIP_EN drops the redundant half of a pair:
//      - lo == 0                -> LUI/AUIPC alone (out_last with it)
//      - mode 0 and up == 0     -> single ADDI rd, x0, lo
//    AUIPC is never dropped. The default build always emits two words.
//
//    state_dbg exposes the FSM state (0 IDLE, 1 FIRST, 2 SECOND).

module encode_upperimm_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_mode,
   input  logic [4:0]  in_rd,
   input  logic [31:0] in_value,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        out_last,
   output logic        busy,
   output logic [1:0]  state_dbg
);

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_IMM   = 7'b0010011;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRST  = 2'd1,
      SECOND = 2'd2
   } state_t;

   state_t      state;
   logic        ready_q;
   logic [4:0]  rd_q;
   logic [11:0] lo_q;

   logic [11:0] lo_in;
   logic [19:0] up_in;
   logic [6:0]  opc_in;
   logic [31:0] first_word;
   logic        first_last;

   // Split the incoming value; the upper part absorbs the sign of lo so that
   // the ADDI's sign-extended immediate lands back on the original value.
   always_comb begin
      lo_in      = in_value[11:0];
      up_in      = in_value[31:12] + {19'd0, in_value[11]};
      opc_in     = in_mode ? OP_AUIPC : OP_LUI;
      first_word = {up_in, in_rd, opc_in};
      first_last = 1'b0;
`ifdef UPPERIMM_SKIP_EN
      if (lo_in == 12'd0) begin
         first_last = 1'b1;
      end else if (!in_mode && (up_in == 20'd0)) begin
         first_word = {lo_in, 5'd0, 3'b000, in_rd, OP_IMM};
         first_last = 1'b1;
      end
`endif
   end

   // Sequencer: accept in IDLE, then emit the upper word and the ADDI word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ready_q   <= 1'b0;
         rd_q      <= 5'd0;
         lo_q      <= 12'd0;
         out_valid <= 1'b0;
         out_instr <= 32'd0;
         out_last  <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  rd_q      <= in_rd;
                  lo_q      <= lo_in;
                  state     <= FIRST;
                  out_valid <= 1'b1;
                  out_instr <= first_word;
                  out_last  <= first_last;
               end
            end
            FIRST: begin
               if (out_ready) begin
                  if (out_last) begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     out_instr <= 32'd0;
                     out_last  <= 1'b0;
                  end else begin
                     state     <= SECOND;
                     out_instr <= {lo_q, rd_q, 3'b000, rd_q, OP_IMM};
                     out_last  <= 1'b1;
                  end
               end
            end
            SECOND: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  out_instr <= 32'd0;
                  out_last  <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               out_instr <= 32'd0;
               out_last  <= 1'b0;
            end
         endcase
      end
   end

   // ready_q keeps in_ready low until the first clock after reset release.
   always_comb begin
      in_ready  = ready_q && (state == IDLE);
      busy      = (state != IDLE);
      state_dbg = state;
   end

endmodule

// File: tb/tb_encode_upperimm_seq.sv
// Bench for encode_upperimm_seq: directed vectors with hand-computed words.
// The driver pushes {last, instr} into exp_q on issue; a monitor pops and
// compares on every accepted output beat.

module tb_encode_upperimm_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_mode;
   logic [4:0]  in_rd;
   logic [31:0] in_value;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_last;
   logic        busy;
   logic [1:0]  state_dbg;

   int total = 0;
   int bad   = 0;

   logic [32:0] exp_q[$];

   encode_upperimm_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_rd     (in_rd),
      .in_value  (in_value),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_last  (out_last),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every accepted beat must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got %h last=%0b expected none", out_instr, out_last);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            chk("out_word", {out_last, out_instr}, e);
         end
      end
   end

   // Driver: called at posedge+1; waits for in_ready, issues one request.
   task automatic send(input logic mode, input logic [4:0] rd, input logic [31:0] value,
                       input logic [31:0] w0, input logic w0_last, input logic [31:0] w1);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) chk("send_timeout", 33'd0, 33'd1);
      in_valid = 1'b1;
      in_mode  = mode;
      in_rd    = rd;
      in_value = value;
      exp_q.push_back({w0_last, w0});
      if (!w0_last) exp_q.push_back({1'b1, w1});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busy || exp_q.size() != 0) chk("idle_timeout", 33'd0, 33'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_mode   = 1'b0;
      in_rd     = 5'd0;
      in_value  = 32'd0;
      out_ready = 1'b1;

      // Reset state
      #12;
      chk("rst_out_valid", {32'd0, out_valid}, 33'd0);
      chk("rst_out_instr", {1'b0, out_instr}, 33'd0);
      chk("rst_in_ready",  {32'd0, in_ready}, 33'd0);
      chk("rst_busy",      {32'd0, busy}, 33'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_rst", {32'd0, in_ready}, 33'd1);
      chk("state_idle", {31'd0, state_dbg}, 33'd0);

      // Basic vectors
      send(1'b0, 5'd5, 32'h12345678, 32'h123452B7, 1'b0, 32'h67828293);
      wait_idle();
      send(1'b0, 5'd1, 32'h00000800, 32'h000010B7, 1'b0, 32'h80008093);
      wait_idle();
`ifdef UPPERIMM_SKIP_EN
      send(1'b0, 5'd10, 32'hFFFFF800, 32'h80000513, 1'b1, 32'h0);
      wait_idle();
      send(1'b1, 5'd6, 32'h00001000, 32'h00001317, 1'b1, 32'h0);
      wait_idle();
`else
      send(1'b0, 5'd10, 32'hFFFFF800, 32'h00000537, 1'b0, 32'h80050513);
      wait_idle();
      send(1'b1, 5'd6, 32'h00001000, 32'h00001317, 1'b0, 32'h00030313);
      wait_idle();
`endif
      // rd = x0, AUIPC with up wrapping to zero
      send(1'b1, 5'd0, 32'hFFFFFFFF, 32'h00000017, 1'b0, 32'hFFF00013);
      wait_idle();
      send(1'b0, 5'd31, 32'h7FFFF7FF, 32'h7FFFFFB7, 1'b0, 32'h7FFF8F93);
      wait_idle();

      // Back-to-back requests without waiting for idle
      send(1'b0, 5'd5, 32'h12345678, 32'h123452B7, 1'b0, 32'h67828293);
      send(1'b0, 5'd1, 32'h00000800, 32'h000010B7, 1'b0, 32'h80008093);
      wait_idle();

      // Backpressure in FIRST; a new request while busy must be ignored
      out_ready = 1'b0;
      send(1'b0, 5'd5, 32'h12345678, 32'h123452B7, 1'b0, 32'h67828293);
      in_valid = 1'b1;
      in_mode  = 1'b1;
      in_rd    = 5'd9;
      in_value = 32'hDEADBEEF;
      for (int i = 0; i < 3; i++) begin
         chk("stall_instr", {out_last, out_instr}, {1'b0, 32'h123452B7});
         chk("stall_in_ready", {32'd0, in_ready}, 33'd0);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_idle();

      // Reset in FIRST drops the sequence
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_mode   = 1'b0;
      in_rd     = 5'd3;
      in_value  = 32'h00012345;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("pre_rst_valid", {32'd0, out_valid}, 33'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {32'd0, out_valid}, 33'd0);
      chk("mid_rst_instr", {out_last, out_instr}, 33'd0);
      chk("mid_rst_busy", {32'd0, busy}, 33'd0);
      chk("mid_rst_in_ready", {32'd0, in_ready}, 33'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
      end
      chk("post_rst_valid", {32'd0, out_valid}, 33'd0);
      send(1'b0, 5'd1, 32'h00000800, 32'h000010B7, 1'b0, 32'h80008093);
      wait_idle();

      chk("queue_empty", {1'b0, 32'(exp_q.size())}, 33'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/encode_upperimm_seq.md
ENCODE_UPPERIMM_SEQ -- requirements
Module: encode_upperimm_seq

Interface
REQ-001 SHALL have ports: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have ports: rst_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have ports: in_valid  input  1  request valid.
REQ-004 SHALL have ports: in_ready  output  1  request accepted when in_valid&&in_ready.
REQ-005 SHALL have ports: in_mode  input  1  0 = load-immediate (LUI base), 1 = PC-relative (AUIPC base).
REQ-006 SHALL have ports: in_rd  input  5  destination register.
REQ-007 SHALL have ports: in_value  input  32  constant (mode 0) or PC offset (mode 1).
REQ-008 SHALL have ports: out_valid  output  1  out_instr valid.
REQ-009 SHALL have ports: out_ready  input  1  consumer accepts when out_valid&&out_ready.
REQ-010 SHALL have ports: out_instr  output  32  encoded RV32I instruction word.
REQ-011 SHALL have ports: out_last  output  1  high with final instruction of a sequence.
REQ-012 SHALL have ports: busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement states IDLE, FIRST, SECOND; in_ready = (state==IDLE); one request in flight.
REQ-014 SHALL, on accept in IDLE, register in_mode/in_rd/in_value, compute lo = value[11:0], up = value[31:12] + value[11] (20-bit, modulo 2^20), and enter FIRST next cycle (latency 1 cycle accept-to-out_valid).
REQ-015 SHALL in FIRST drive out_valid=1, out_instr = {up, rd, 7'b0110111} (mode 0) or {up, rd, 7'b0010111} (mode 1).
REQ-016 SHALL in SECOND drive out_valid=1, out_instr = ADDI {lo, rs1=rd, 3'b000, rd, 7'b0010011}, out_last=1.
REQ-017 SHALL advance FIRST->SECOND and SECOND->IDLE only on out_valid&&out_ready; out_instr/out_last held stable while out_ready=0.
REQ-018 SHALL drive out_valid=0, out_last=0, out_instr=0 in IDLE.
REQ-019 SHALL encode rd=x0 unchanged (no special case).
REQ-020 SHALL wrap up silently when value[31:12]=0xFFFFF and value[11]=1 (up=0x00000).
REQ-021 SHALL ignore in_* while busy; no request is lost or duplicated.

Reset
REQ-022 SHALL on rst_n=0 immediately force state=IDLE, out_valid=0, out_last=0, out_instr=0, busy=0, in_ready=0 while asserted; in_ready=1 from first clock after release.
REQ-023 SHALL discard any in-flight sequence on reset; no partial sequence resumes.

Configuration
REQ-024 SHALL support macro UPPERIMM_SKIP_EN; when undefined every sequence is exactly two instructions (FIRST then SECOND).
REQ-025 SHALL with UPPERIMM_SKIP_EN defined: mode 0, lo==0 -> LUI only (out_last=1 in FIRST); mode 0, up==0 -> single ADDI rd,x0,lo (rs1=x0, out_last=1); mode 1, lo==0 -> AUIPC only; AUIPC never skipped.

Verification
REQ-026 SHALL check mode0 rd=5 value=0x12345678 -> 0x123452B7 then 0x67828293 (out_last on 2nd).
REQ-027 SHALL check mode0 rd=1 value=0x00000800 -> 0x000010B7 then 0x80008093 (sign compensation).
REQ-028 SHALL check mode0 rd=10 value=0xFFFFF800 -> 0x00000537, 0x80050513; with UPPERIMM_SKIP_EN only 0x80000513, out_last=1.
REQ-029 SHALL check mode1 rd=6 value=0x00001000 -> 0x00001317, 0x00030313; with UPPERIMM_SKIP_EN only 0x00001317, out_last=1.
REQ-030 SHALL check out_ready=0 for 3 cycles in FIRST -> out_instr constant, in_ready=0, new in_valid ignored, then sequence completes normally.
REQ-031 SHALL check rst_n low while in FIRST -> out_valid=0 same cycle, no SECOND emitted, next request encodes correctly.
